// File: rtl/sqrt_result_bcd_if.sv
// sqrt_result_bcd_if
//   Groups the result bus between the sqrt unit, the BCD conversion stage and
//   the display/report logic.
//   master : drives yint_i/ydec_i/fl_i and observes the BCD results
//   slave  : the conversion stage (samples inputs, drives results)
//   yint_i    2*N+1      integer part of the sqrt result
//   ydec_i    DIGIT      binary fraction (value = ydec_i / 2^DIGIT)
//   fl_i      1          result-ready level flag
//   bcd_int_o 4*INT_DIG  packed BCD integer, LSD in [3:0]
//   bcd_dec_o 4*DEC_DIG  packed BCD fraction, first digit in MS nibble
//   valid_o   1          one-cycle pulse when bcd_*_o update
//   busy_o    1          conversion in progress
interface sqrt_result_bcd_if #(
    parameter int N       = 16,
    parameter int DIGIT   = 32,
    parameter int INT_DIG = 10,
    parameter int DEC_DIG = 4
);
    logic [2*N:0]           yint_i;
    logic [DIGIT-1:0]       ydec_i;
    logic                   fl_i;
    logic [4*INT_DIG-1:0]   bcd_int_o;
    logic [4*DEC_DIG-1:0]   bcd_dec_o;
    logic                   valid_o;
    logic                   busy_o;

    modport master (
        output yint_i, ydec_i, fl_i,
        input  bcd_int_o, bcd_dec_o, valid_o, busy_o
    );

    modport slave (
        input  yint_i, ydec_i, fl_i,
        output bcd_int_o, bcd_dec_o, valid_o, busy_o
    );
endinterface

// File: rtl/sqrt_result_bcd.sv
// sqrt_result_bcd
//   Captures the fixed-point sqrt result on the rising edge of fl_i, converts
//   the integer part to packed BCD with a sequential double-dabble and the
//   binary fraction to DEC_DIG truncated decimal digits by repeated x10, then
//   presents both with a one-cycle valid pulse.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-low
//   bus    : sqrt_result_bcd_if.slave (yint_i, ydec_i, fl_i in;
//            bcd_int_o, bcd_dec_o, valid_o, busy_o out)
module sqrt_result_bcd #(
    parameter int N       = 16,
    parameter int DIGIT   = 32,
    parameter int INT_DIG = 10,
    parameter int DEC_DIG = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sqrt_result_bcd_if.slave     bus
);
    localparam int YW  = 2*N + 1;
    localparam int BW  = 4*INT_DIG;
    localparam int DW  = 4*DEC_DIG;
    localparam int CW  = $clog2(YW);
    localparam int DCW = (DEC_DIG > 1) ? $clog2(DEC_DIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV_INT,
        CONV_DEC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [YW-1:0]    shreg_q;
    logic [BW-1:0]    scratch_q;
    logic [BW-1:0]    adj;
    logic [DIGIT-1:0] frac_q;
    logic [DIGIT+3:0] prod;
    logic [DW-1:0]    dec_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [DCW-1:0]   dec_cnt_q;
    logic [BW-1:0]    bcd_int_q;
    logic [DW-1:0]    bcd_dec_q;
    logic             valid_q;
    logic             fl_q;

    logic start, capture, shift_int, shift_dec, finish, busy;
    logic last_bit, last_dig;

    // fl_q resets high so a flag already asserted out of reset is not a start.
    assign start    = bus.fl_i && !fl_q;
    assign last_bit = (bit_cnt_q == CW'(YW-1));
    assign last_dig = (dec_cnt_q == DCW'(DEC_DIG-1));

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start)    state_d = CONV_INT;
            CONV_INT: if (last_bit) state_d = CONV_DEC;
            CONV_DEC: if (last_dig) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        capture   = 1'b0;
        shift_int = 1'b0;
        shift_dec = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE:     capture   = start;
            CONV_INT: begin shift_int = 1'b1; busy = 1'b1; end
            CONV_DEC: begin shift_dec = 1'b1; busy = 1'b1; end
            DONE:     begin finish    = 1'b1; busy = 1'b1; end
            default:  ;
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < INT_DIG; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            else                             adj[4*i +: 4] = scratch_q[4*i +: 4];
        end
    end

    // frac*10 as (frac<<3)+(frac<<1); the top nibble is the next decimal digit.
    assign prod = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg_q   <= '0;
            scratch_q <= '0;
            frac_q    <= '0;
            dec_q     <= '0;
            bit_cnt_q <= '0;
            dec_cnt_q <= '0;
            bcd_int_q <= '0;
            bcd_dec_q <= '0;
            valid_q   <= 1'b0;
            fl_q      <= 1'b1;
        end else begin
            fl_q    <= bus.fl_i;
            valid_q <= finish;
            if (capture) begin
                shreg_q   <= bus.yint_i;
                frac_q    <= bus.ydec_i;
                scratch_q <= '0;
                dec_q     <= '0;
                bit_cnt_q <= '0;
                dec_cnt_q <= '0;
            end
            if (shift_int) begin
                {scratch_q, shreg_q} <= {adj, shreg_q} << 1;
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            end
            if (shift_dec) begin
                dec_q     <= {dec_q[DW-5:0], prod[DIGIT+3:DIGIT]};
                frac_q    <= prod[DIGIT-1:0];
                dec_cnt_q <= last_dig ? '0 : dec_cnt_q + 1'b1;
            end
            if (finish) begin
                bcd_int_q <= scratch_q;
                bcd_dec_q <= dec_q;
            end
        end
    end

    assign bus.bcd_int_o = bcd_int_q;
    assign bus.bcd_dec_o = bcd_dec_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy;
endmodule

// File: tb/tb_sqrt_result_bcd.sv
module tb_sqrt_result_bcd;
    localparam int N       = 16;
    localparam int DIGIT   = 32;
    localparam int INT_DIG = 10;
    localparam int DEC_DIG = 4;
    localparam int YW      = 2*N + 1;
    localparam int BW      = 4*INT_DIG;
    localparam int DW      = 4*DEC_DIG;
    localparam int LAT     = 2*N + DEC_DIG + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sqrt_result_bcd_if #(.N(N), .DIGIT(DIGIT), .INT_DIG(INT_DIG), .DEC_DIG(DEC_DIG)) bus ();

    sqrt_result_bcd #(.N(N), .DIGIT(DIGIT), .INT_DIG(INT_DIG), .DEC_DIG(DEC_DIG)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int valid_count = 0;

    always @(negedge clk) if (bus.valid_o === 1'b1) valid_count++;

    // Reference: decimal digits by plain division / multiplication.
    function automatic void model(input logic [YW-1:0] y, input logic [DIGIT-1:0] f,
                                  output logic [BW-1:0] bi, output logic [DW-1:0] bd);
        longint unsigned v, fr;
        v  = longint'(y);
        bi = '0;
        for (int i = 0; i < INT_DIG; i++) begin
            bi[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        fr = longint'(f);
        bd = '0;
        for (int i = 0; i < DEC_DIG; i++) begin
            fr = fr * 10;
            bd[4*(DEC_DIG-1-i) +: 4] = 4'(fr >> DIGIT);
            fr = fr & ((64'd1 << DIGIT) - 1);
        end
    endfunction

    // Drives one conversion and collects observations; bounded at 100 cycles.
    task automatic convert(input logic [YW-1:0] y, input logic [DIGIT-1:0] f,
                           output int lat, output logic busy_start,
                           output logic [BW-1:0] bi, output logic [DW-1:0] bd,
                           output logic busy_at_valid, output logic valid_next);
        bus.fl_i = 1'b0;
        @(posedge clk); #1;
        bus.yint_i = y;
        bus.ydec_i = f;
        bus.fl_i   = 1'b1;
        @(posedge clk); #1;
        busy_start = bus.busy_o;
        bus.yint_i = ~y;
        bus.ydec_i = ~f;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.valid_o === 1'b1) break;
        end
        bi = bus.bcd_int_o;
        bd = bus.bcd_dec_o;
        busy_at_valid = bus.busy_o;
        @(posedge clk); #1;
        valid_next = bus.valid_o;
    endtask

    task automatic test_reset();
        int lat; logic bs, bv, vn;
        logic [BW-1:0] bi; logic [DW-1:0] bd;
        rst_n = 1'b0;
        bus.fl_i = 1'b1;
        bus.yint_i = 33'd77;
        bus.ydec_i = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.bcd_int_o !== '0 || bus.bcd_dec_o !== '0 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs int=%h dec=%h valid=%b busy=%b required all zero",
                     bus.bcd_int_o, bus.bcd_dec_o, bus.valid_o, bus.busy_o);
        end
        rst_n = 1'b1;
        valid_count = 0;
        repeat (45) @(posedge clk);
        #1;
        checks++;
        if (valid_count !== 0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flag_high_at_reset valid_pulses=%0d busy=%b required 0/0", valid_count, bus.busy_o);
        end
        convert(33'd5, 32'd0, lat, bs, bi, bd, bv, vn);
        checks++;
        if (lat !== LAT || bs !== 1'b1) begin
            failures++;
            $display("FAIL first_latency got=%0d busy=%b required=%0d busy=1", lat, bs, LAT);
        end
        checks++;
        if (bi !== 40'h0000000005 || bd !== 16'h0000) begin
            failures++;
            $display("FAIL yint5 got=%h.%h required=0000000005.0000", bi, bd);
        end
    endtask

    task automatic test_directed();
        int lat; logic bs, bv, vn;
        logic [BW-1:0] bi; logic [DW-1:0] bd;
        convert(33'd1, 32'h6A09E667, lat, bs, bi, bd, bv, vn);
        checks++;
        if (bi !== 40'h0000000001 || bd !== 16'h4142) begin
            failures++;
            $display("FAIL sqrt2 got=%h.%h required=0000000001.4142", bi, bd);
        end
        checks++;
        if (bv !== 1'b0 || vn !== 1'b0) begin
            failures++;
            $display("FAIL valid_pulse busy_at_valid=%b valid_next=%b required 0/0", bv, vn);
        end
        convert(33'h1FFFFFFFF, 32'hFFFFFFFF, lat, bs, bi, bd, bv, vn);
        checks++;
        if (bi !== 40'h8589934591 || bd !== 16'h9999 || lat !== LAT) begin
            failures++;
            $display("FAIL max_value got=%h.%h lat=%0d required=8589934591.9999 lat=%0d", bi, bd, lat, LAT);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.bcd_int_o !== 40'h8589934591 || bus.bcd_dec_o !== 16'h9999) begin
            failures++;
            $display("FAIL hold got=%h.%h required=8589934591.9999", bus.bcd_int_o, bus.bcd_dec_o);
        end
    endtask

    task automatic test_ignore_busy();
        logic [BW-1:0] ei; logic [DW-1:0] ed;
        model(33'd777, 32'h40000000, ei, ed);
        bus.fl_i = 1'b0;
        @(posedge clk); #1;
        bus.yint_i = 33'd777;
        bus.ydec_i = 32'h40000000;
        valid_count = 0;
        bus.fl_i = 1'b1;
        @(posedge clk); #1;
        bus.yint_i = 33'd99;
        bus.ydec_i = 32'h12345678;
        repeat (4) @(posedge clk); #1 bus.fl_i = 1'b0;
        repeat (3) @(posedge clk); #1 bus.fl_i = 1'b1;
        repeat (3) @(posedge clk); #1 bus.fl_i = 1'b0;
        repeat (3) @(posedge clk); #1 bus.fl_i = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (valid_count !== 1) begin
            failures++;
            $display("FAIL busy_toggle_pulses got=%0d required=1", valid_count);
        end
        checks++;
        if (bus.bcd_int_o !== ei || bus.bcd_dec_o !== ed) begin
            failures++;
            $display("FAIL busy_toggle_data got=%h.%h required=%h.%h", bus.bcd_int_o, bus.bcd_dec_o, ei, ed);
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (valid_count !== 1 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL held_flag_restart pulses=%0d busy=%b required 1/0", valid_count, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic bs, bv, vn;
        logic [BW-1:0] bi; logic [DW-1:0] bd;
        bus.fl_i = 1'b0;
        @(posedge clk); #1;
        bus.yint_i = 33'd4242;
        bus.ydec_i = 32'h0;
        bus.fl_i   = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.bcd_int_o !== '0 || bus.bcd_dec_o !== '0 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset int=%h dec=%h valid=%b busy=%b required all zero",
                     bus.bcd_int_o, bus.bcd_dec_o, bus.valid_o, bus.busy_o);
        end
        valid_count = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (valid_count !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_valid pulses=%0d required=0", valid_count);
        end
        convert(33'd12345, 32'h80000000, lat, bs, bi, bd, bv, vn);
        checks++;
        if (bi !== 40'h0000012345 || bd !== 16'h5000 || lat !== LAT) begin
            failures++;
            $display("FAIL after_reset got=%h.%h lat=%0d required=0000012345.5000 lat=%0d", bi, bd, lat, LAT);
        end
    endtask

    task automatic test_random();
        int lat; logic bs, bv, vn;
        logic [BW-1:0] bi, ei; logic [DW-1:0] bd, ed;
        logic [YW-1:0] y; logic [DIGIT-1:0] f;
        for (int it = 0; it < 20; it++) begin
            if (it == 0) begin
                y = '0; f = '0;
            end else begin
                y = {1'($urandom_range(0, 1)), 32'($urandom)};
                f = 32'($urandom);
            end
            model(y, f, ei, ed);
            convert(y, f, lat, bs, bi, bd, bv, vn);
            checks++;
            if (bi !== ei || bd !== ed) begin
                failures++;
                $display("FAIL random_%0d y=%0d f=%h got=%h.%h required=%h.%h", it, y, f, bi, bd, ei, ed);
            end
            checks++;
            if (lat !== LAT || bs !== 1'b1 || bv !== 1'b0 || vn !== 1'b0) begin
                failures++;
                $display("FAIL random_timing_%0d lat=%0d busy_start=%b busy_valid=%b valid_next=%b required %0d/1/0/0",
                         it, lat, bs, bv, vn, LAT);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.fl_i = 1'b0;
        bus.yint_i = '0;
        bus.ydec_i = '0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
